// File: rtl/cordic_sqrt_sched.sv
// cordic_sqrt_sched: round-robin sharing of one free-running pipelined sqrt core.
// Issue is gated by FIFO credits, so every in-flight result already owns a slot in the tagged result FIFO.
module cordic_sqrt_sched #(
    parameter int DSIZE = 16,
    parameter int NREQ  = 4,
    parameter int LAT   = 6,
    parameter int DEPTH = 8,
    parameter int TW    = $clog2(NREQ)
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid_i,
    input  logic [NREQ*DSIZE-1:0] req_data_i,
    output logic [NREQ-1:0]       req_ready_o,
    output logic [DSIZE-1:0]      core_d_o,
    input  logic [DSIZE-1:0]      core_q_i,
    output logic                  rsp_valid_o,
    output logic [TW-1:0]         rsp_tag_o,
    output logic [DSIZE-1:0]      rsp_data_o,
    input  logic                  rsp_ready_i,
    output logic                  idle_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic                run_q;
    logic [CW-1:0]       credit_q, credit_d;
    logic [TW-1:0]       ptr_q, ptr_d, gidx, idx;
    logic                found, credit_ok, issue, pop, push, empty, full;
    logic [LAT-1:0]      v_q;
    logic [TW-1:0]       tag_q [LAT];
    logic [AW:0]         wp_q, rp_q;
    logic [TW+DSIZE-1:0] mem [DEPTH];

    // first valid requester after the last granted one, wrapping
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = TW'((int'(ptr_q) + k) % NREQ);
            if (!found && req_valid_i[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
    end

    assign credit_ok   = run_q && (credit_q < CW'(DEPTH));
    assign issue       = found && credit_ok;
    assign req_ready_o = issue ? ({{(NREQ-1){1'b0}}, 1'b1} << gidx) : '0;
    assign core_d_o    = found ? req_data_i[int'(gidx)*DSIZE +: DSIZE] : '0;
    assign ptr_d       = issue ? gidx : ptr_q;

    assign empty       = (wp_q == rp_q);
    assign full        = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign push        = v_q[LAT-1];
    assign pop         = rsp_valid_o && rsp_ready_i;
    assign credit_d    = credit_q + CW'(issue) - CW'(pop);

    assign rsp_valid_o = !empty;
    assign {rsp_tag_o, rsp_data_o} = empty ? '0 : mem[rp_q[AW-1:0]];
    assign idle_o      = (credit_q == '0);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            run_q    <= 1'b0;
            credit_q <= '0;
            ptr_q    <= TW'(NREQ - 1);
            v_q      <= '0;
            wp_q     <= '0;
            rp_q     <= '0;
        end else begin
            run_q    <= 1'b1;
            credit_q <= credit_d;
            ptr_q    <= ptr_d;
            v_q      <= {v_q[LAT-2:0], issue};
            wp_q     <= wp_q + (AW+1)'(push);
            rp_q     <= rp_q + (AW+1)'(pop);
        end
    end

    // tags and payload are qualified by v_q and the FIFO pointers, so they need no reset
    always_ff @(posedge clock) begin
        tag_q[0] <= gidx;
        for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
        if (push) mem[wp_q[AW-1:0]] <= {tag_q[LAT-1], core_q_i};
    end

    a_no_overflow: assert property (@(posedge clock) disable iff (!rst_n) !(push && full));

endmodule
